mem_stage_access_unit: RTL and testbench
========================================

MEM_STAGE_ACCESS_UNIT -- requirements
Module: mem_stage_access_unit

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 255, BUSY cycles without Dmem_Ack before abort (used only with MEM_ACK_TIMEOUT_EN).
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- Clk  in  1  single clock, all state updates on posedge
- Reset_n  in  1  reset, synchronous, active-low
- RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM  in  1 each  MEM-stage control/flag inputs
- Branch_Dest_MEM, ALU_Result_MEM, Write_Data_MEM  in  32 each  branch target, address/ALU result, store data
- Write_Register_MEM  in  5  destination register
- Dmem_Rdata  in  32  memory read data, valid with Dmem_Ack
- Dmem_Ack  in  1  memory completion
- Dmem_Req, Dmem_We  out  1 each  request, write enable
- Dmem_Addr, Dmem_Wdata  out  32 each  word address, store data
- Stall_MEM  out  1  hold EX/MEM and earlier stages
- PCSrc  out  1  take branch
- Branch_Target  out  32  branch destination
- RegWrite_WB, MemtoReg_WB  out  1 each  MEM/WB control
- Read_Data_WB, ALU_Result_WB  out  32 each  MEM/WB data
- Write_Register_WB  out  5  MEM/WB destination
- Align_Error, Timeout_Error  out  1 each  one-cycle error pulses

Function
REQ-003 SHALL implement FSM states IDLE and BUSY.
REQ-004 SHALL define mem_op = MemRead_MEM | MemWrite_MEM; aligned = (ALU_Result_MEM[1:0] == 0); MemWrite_MEM takes priority if both set.
REQ-005 IDLE, mem_op & aligned: SHALL register Dmem_Req=1, Dmem_We=MemWrite_MEM, Dmem_Addr=ALU_Result_MEM, Dmem_Wdata=Write_Data_MEM; go BUSY.
REQ-006 BUSY: Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata SHALL stay stable until the edge on which Dmem_Ack=1 is sampled.
REQ-007 BUSY, Dmem_Ack=1: SHALL drop Dmem_Req at that edge and go IDLE; Dmem_Ack in IDLE SHALL be ignored.
REQ-008 Stall_MEM SHALL be combinational: 1 when (IDLE & mem_op & aligned) or (BUSY & ~Dmem_Ack), else 0.
REQ-009 When Stall_MEM=1, MEM/WB SHALL load a bubble: RegWrite_WB=0, MemtoReg_WB=0; other WB outputs hold.
REQ-010 When Stall_MEM=0, MEM/WB SHALL load RegWrite/MemtoReg/ALU_Result/Write_Register from MEM inputs; Read_Data_WB=Dmem_Rdata on loads completing this cycle, else hold.
REQ-011 Latency: non-memory instruction 1 cycle; memory access minimum 2 cycles (Ack in first BUSY cycle), +1 per wait cycle.
REQ-012 mem_op & ~aligned in IDLE: SHALL issue no request, not stall, pulse Align_Error one cycle, load MEM/WB with RegWrite_WB=0.
REQ-013 PCSrc SHALL equal Branch_MEM & Zero_MEM and Branch_Target SHALL equal Branch_Dest_MEM, combinationally, not gated by stall.
REQ-014 Back-to-back memory ops: the next op SHALL start from IDLE in the cycle after completion; no idle gap beyond that.

Reset
REQ-015 Reset_n=0 at a posedge SHALL force IDLE and zero every registered output (Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, all *_WB, error pulses, timeout counter).
REQ-016 Reset during BUSY SHALL abandon the access: Dmem_Req=0 after that edge, no MEM/WB write.

Configuration
REQ-017 With MEM_ACK_TIMEOUT_EN defined: counter clears on entering BUSY, increments per BUSY cycle without Ack; at TIMEOUT_CYCLES SHALL drop Dmem_Req, go IDLE, pulse Timeout_Error, force Stall_MEM=0 that cycle, retire as bubble (RegWrite_WB=0).
REQ-018 Without MEM_ACK_TIMEOUT_EN: BUSY SHALL wait indefinitely; Timeout_Error tied 0; no counter logic.

Verification
REQ-019 Load, ALU_Result=0x100, Ack in first BUSY cycle, Rdata=0xDEADBEEF -> Req 1 cycle, Stall 1 cycle, Read_Data_WB=0xDEADBEEF, RegWrite_WB=1 next cycle.
REQ-020 Store 0x12345678 to 0x200, Ack after 3 wait cycles -> Req/We/Addr/Wdata stable 4 cycles, Stall 4 cycles, bubbles during stall.
REQ-021 Load at 0x102 -> Dmem_Req never 1, Align_Error 1-cycle pulse, RegWrite_WB=0, no stall.
REQ-022 Branch_MEM=1, Zero_MEM=1, Branch_Dest=0x40 -> PCSrc=1, Branch_Target=0x40 same cycle.
REQ-023 Reset_n=0 during BUSY -> next cycle Dmem_Req=0, IDLE, all outputs 0; late Ack ignored.
REQ-024 MEM_ACK_TIMEOUT_EN, no Ack -> after 255 BUSY cycles Timeout_Error pulse, Req=0, Stall=0, RegWrite_WB=0.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_access_unit
//
// MEM-stage data memory access unit for a 5-stage pipeline. It issues one
// word-aligned load or store at a time on a simple request/ack memory port.
// While the access is outstanding it stalls the upstream pipeline and feeds
// bubbles into MEM/WB. It also resolves branches combinationally and
// registers the MEM/WB pipeline state.
//
// Optional feature (compile-time macro):
//   MEM_ACK_TIMEOUT_EN : abort an access after TIMEOUT_CYCLES BUSY cycles
//                        without Dmem_Ack. Timeout_Error pulses and the
//                        instruction retires as a bubble. Without the macro,
//                        BUSY waits indefinitely and Timeout_Error is tied 0.
//
// Parameters:
//   TIMEOUT_CYCLES : BUSY cycles without ack before abort (timeout build only)
//
// Ports:
//   Clk, Reset_n          clock; synchronous active-low reset
//   *_MEM                 EX/MEM control, flags, address/ALU result, store
//                         data and destination register
//   Dmem_Rdata, Dmem_Ack  memory read data and completion
//   Dmem_Req/We/Addr/Wdata registered memory request, stable while BUSY
//   Stall_MEM             combinational hold for EX/MEM and earlier stages
//   PCSrc, Branch_Target  combinational branch resolution
//   *_WB                  MEM/WB pipeline register outputs
//   Align_Error           one-cycle pulse on a misaligned memory op
//   Timeout_Error         one-cycle pulse on an ack timeout
// -----------------------------------------------------------------------------
module mem_stage_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        RegWrite_MEM,
    input  logic        MemtoReg_MEM,
    input  logic        Branch_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        Zero_MEM,
    input  logic [31:0] Branch_Dest_MEM,
    input  logic [31:0] ALU_Result_MEM,
    input  logic [31:0] Write_Data_MEM,
    input  logic [4:0]  Write_Register_MEM,
    input  logic [31:0] Dmem_Rdata,
    input  logic        Dmem_Ack,
    output logic        Dmem_Req,
    output logic        Dmem_We,
    output logic [31:0] Dmem_Addr,
    output logic [31:0] Dmem_Wdata,
    output logic        Stall_MEM,
    output logic        PCSrc,
    output logic [31:0] Branch_Target,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [31:0] Read_Data_WB,
    output logic [31:0] ALU_Result_WB,
    output logic [4:0]  Write_Register_WB,
    output logic        Align_Error,
    output logic        Timeout_Error
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [0:0] state;
    logic       mem_op, aligned, in_idle, in_busy;
    logic       issue, misalign, done, tmo_hit;

    assign mem_op   = MemRead_MEM | MemWrite_MEM;
    assign aligned  = (ALU_Result_MEM[1:0] == 2'b00);
    assign in_idle  = (state == IDLE);
    assign in_busy  = (state == BUSY);
    assign issue    = in_idle & mem_op & aligned;
    assign misalign = in_idle & mem_op & ~aligned;
    assign done     = in_busy & Dmem_Ack;

    // The stall is released on the ack cycle itself, so the completing
    // instruction retires at the same edge that drops the request. The next
    // op can then start from IDLE in the following cycle.
    assign Stall_MEM     = issue | (in_busy & ~Dmem_Ack & ~tmo_hit);
    assign PCSrc         = Branch_MEM & Zero_MEM;
    assign Branch_Target = Branch_Dest_MEM;

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt;

    // tmo_cnt holds the number of ack-less BUSY cycles already elapsed. The
    // abort therefore fires in the TIMEOUT_CYCLES-th ack-less BUSY cycle.
    assign tmo_hit = in_busy & ~Dmem_Ack &
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            tmo_cnt       <= '0;
            Timeout_Error <= 1'b0;
        end else begin
            Timeout_Error <= tmo_hit;
            if (issue)
                tmo_cnt <= '0;
            else if (in_busy & ~Dmem_Ack & ~tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit       = 1'b0;
    assign Timeout_Error = 1'b0;
`endif

    // Request FSM: the request fields are captured on issue and left
    // untouched while BUSY. This keeps them stable until the ack edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            Dmem_Req    <= 1'b0;
            Dmem_We     <= 1'b0;
            Dmem_Addr   <= '0;
            Dmem_Wdata  <= '0;
            Align_Error <= 1'b0;
        end else begin
            Align_Error <= misalign;
            if (in_idle) begin
                if (issue) begin
                    state      <= BUSY;
                    Dmem_Req   <= 1'b1;
                    Dmem_We    <= MemWrite_MEM;
                    Dmem_Addr  <= ALU_Result_MEM;
                    Dmem_Wdata <= Write_Data_MEM;
                end
            end else if (done | tmo_hit) begin
                state    <= IDLE;
                Dmem_Req <= 1'b0;
                Dmem_We  <= 1'b0;
            end
        end
    end

    // MEM/WB register. A stalled or timed-out instruction leaves a bubble.
    // A misaligned op retires with its register write suppressed.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            RegWrite_WB       <= 1'b0;
            MemtoReg_WB       <= 1'b0;
            Read_Data_WB      <= '0;
            ALU_Result_WB     <= '0;
            Write_Register_WB <= '0;
        end else if (Stall_MEM | tmo_hit) begin
            RegWrite_WB <= 1'b0;
            MemtoReg_WB <= 1'b0;
        end else begin
            RegWrite_WB       <= RegWrite_MEM & ~misalign;
            MemtoReg_WB       <= MemtoReg_MEM;
            ALU_Result_WB     <= ALU_Result_MEM;
            Write_Register_WB <= Write_Register_MEM;
            // The registered Dmem_We still describes the completing access.
            if (done & ~Dmem_We)
                Read_Data_WB <= Dmem_Rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mem_stage_access_unit: directed scenarios plus a
// randomized back-to-back instruction stream checked against a
// transaction-level model (an instruction takes 1 cycle, or 2 + waits cycles
// for an aligned memory op).
// -----------------------------------------------------------------------------
module tb_mem_stage_access_unit;

    localparam int TMO = 255;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM;
    logic [31:0] Branch_Dest_MEM, ALU_Result_MEM, Write_Data_MEM, Dmem_Rdata;
    logic [4:0]  Write_Register_MEM;
    logic        Dmem_Ack;
    logic        Dmem_Req, Dmem_We, Stall_MEM, PCSrc, RegWrite_WB, MemtoReg_WB;
    logic        Align_Error, Timeout_Error;
    logic [31:0] Dmem_Addr, Dmem_Wdata, Branch_Target, Read_Data_WB, ALU_Result_WB;
    logic [4:0]  Write_Register_WB;

    int vecs = 0;
    int errs = 0;

    always #5 Clk = ~Clk;

    mem_stage_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .Branch_MEM(Branch_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Zero_MEM(Zero_MEM),
        .Branch_Dest_MEM(Branch_Dest_MEM), .ALU_Result_MEM(ALU_Result_MEM),
        .Write_Data_MEM(Write_Data_MEM), .Write_Register_MEM(Write_Register_MEM),
        .Dmem_Rdata(Dmem_Rdata), .Dmem_Ack(Dmem_Ack),
        .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr), .Dmem_Wdata(Dmem_Wdata),
        .Stall_MEM(Stall_MEM), .PCSrc(PCSrc), .Branch_Target(Branch_Target),
        .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .Read_Data_WB(Read_Data_WB),
        .ALU_Result_WB(ALU_Result_WB), .Write_Register_WB(Write_Register_WB),
        .Align_Error(Align_Error), .Timeout_Error(Timeout_Error)
    );

    // Inputs change 1 time unit after a posedge. Outputs are sampled either
    // 2 units after the posedge (combinational) or 1 unit after it (registered).
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_nop();
        RegWrite_MEM = 0; MemtoReg_MEM = 0; Branch_MEM = 0; MemRead_MEM = 0;
        MemWrite_MEM = 0; Zero_MEM = 0; Branch_Dest_MEM = 0; ALU_Result_MEM = 0;
        Write_Data_MEM = 0; Write_Register_MEM = 0; Dmem_Rdata = 0; Dmem_Ack = 0;
    endtask

    task automatic test_reset();
        logic [138:0] snap;
        Reset_n = 0;
        set_nop();
        MemRead_MEM = 1; RegWrite_MEM = 1; ALU_Result_MEM = 32'h100;
        Write_Register_MEM = 5'd3; Dmem_Ack = 1; Dmem_Rdata = 32'hFFFF_FFFF;
        tick(); tick();
        snap = {Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, RegWrite_WB, MemtoReg_WB,
                Read_Data_WB, ALU_Result_WB, Write_Register_WB, Align_Error, Timeout_Error};
        vecs++;
        if (snap !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", snap); end
        set_nop(); Reset_n = 1;
        #1;
        vecs++;
        if (Stall_MEM !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", Stall_MEM); end
        tick();
    endtask

    task automatic test_load_fast();
        MemRead_MEM = 1; RegWrite_MEM = 1; MemtoReg_MEM = 1;
        ALU_Result_MEM = 32'h100; Write_Register_MEM = 5'd7;
        #1;
        vecs++;
        if ({Stall_MEM, Dmem_Req} !== 2'b10) begin errs++; $display("FAIL load_issue: stall,req got %b want 10", {Stall_MEM, Dmem_Req}); end
        tick();
        vecs++;
        if ({Dmem_Req, Dmem_We, Dmem_Addr, RegWrite_WB} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
            errs++; $display("FAIL load_busy: req,we,addr,rw got %b %b %h %b", Dmem_Req, Dmem_We, Dmem_Addr, RegWrite_WB);
        end
        Dmem_Ack = 1; Dmem_Rdata = 32'hDEADBEEF;
        #1;
        vecs++;
        if (Stall_MEM !== 1'b0) begin errs++; $display("FAIL load_ack_stall: got %b want 0", Stall_MEM); end
        tick();
        vecs++;
        if ({Dmem_Req, RegWrite_WB, MemtoReg_WB, Read_Data_WB, Write_Register_WB} !== {1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd7}) begin
            errs++; $display("FAIL load_retire: req %b rw %b mtr %b rd %h wr %0d want 0 1 1 deadbeef 7",
                             Dmem_Req, RegWrite_WB, MemtoReg_WB, Read_Data_WB, Write_Register_WB);
        end
        set_nop();
    endtask

    task automatic test_store_wait();
        MemWrite_MEM = 1; ALU_Result_MEM = 32'h200; Write_Data_MEM = 32'h12345678;
        RegWrite_MEM = 1; Write_Register_MEM = 5'd4;
        #1;
        vecs++;
        if ({Stall_MEM, Dmem_Req} !== 2'b10) begin errs++; $display("FAIL store_issue: stall,req got %b want 10", {Stall_MEM, Dmem_Req}); end
        tick();
        vecs++;
        if ({RegWrite_WB, MemtoReg_WB} !== 2'b00) begin errs++; $display("FAIL store_bubble0: got %b want 00", {RegWrite_WB, MemtoReg_WB}); end
        for (int k = 1; k <= 4; k++) begin
            Dmem_Ack = (k == 4);
            Dmem_Rdata = $urandom;
            #1;
            vecs++;
            if ({Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, Stall_MEM} !== {1'b1, 1'b1, 32'h200, 32'h12345678, k < 4}) begin
                errs++; $display("FAIL store_busy_%0d: req %b we %b addr %h wdata %h stall %b",
                                 k, Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, Stall_MEM);
            end
            tick();
            vecs++;
            if (RegWrite_WB !== (k == 4)) begin errs++; $display("FAIL store_wb_%0d: rw got %b want %b", k, RegWrite_WB, k == 4); end
        end
        vecs++;
        if ({Dmem_Req, Read_Data_WB} !== {1'b0, 32'hDEADBEEF}) begin
            errs++; $display("FAIL store_done: req %b rd %h want 0 deadbeef", Dmem_Req, Read_Data_WB);
        end
        set_nop();
    endtask

    task automatic test_misaligned();
        MemRead_MEM = 1; RegWrite_MEM = 1; ALU_Result_MEM = 32'h102; Write_Register_MEM = 5'd12;
        #1;
        vecs++;
        if ({Stall_MEM, Dmem_Req} !== 2'b00) begin errs++; $display("FAIL misalign_cycle: stall,req got %b want 00", {Stall_MEM, Dmem_Req}); end
        tick();
        vecs++;
        if ({Dmem_Req, Align_Error, RegWrite_WB} !== 3'b010) begin
            errs++; $display("FAIL misalign_pulse: req,align,rw got %b want 010", {Dmem_Req, Align_Error, RegWrite_WB});
        end
        set_nop();
        #1;
        tick();
        vecs++;
        if ({Dmem_Req, Align_Error} !== 2'b00) begin errs++; $display("FAIL misalign_end: req,align got %b want 00", {Dmem_Req, Align_Error}); end
    endtask

    task automatic test_branch();
        Branch_MEM = 1; Zero_MEM = 1; Branch_Dest_MEM = 32'h40;
        RegWrite_MEM = 1; ALU_Result_MEM = 32'h55; Write_Register_MEM = 5'd9;
        #1;
        vecs++;
        if ({PCSrc, Branch_Target} !== {1'b1, 32'h40}) begin errs++; $display("FAIL branch_taken: got %b %h want 1 40", PCSrc, Branch_Target); end
        Zero_MEM = 0;
        #1;
        vecs++;
        if (PCSrc !== 1'b0) begin errs++; $display("FAIL branch_not_taken: got %b want 0", PCSrc); end
        tick();
        // Branch resolution must not be gated by a memory stall.
        MemRead_MEM = 1; ALU_Result_MEM = 32'h60; Zero_MEM = 1; Branch_Dest_MEM = 32'h80;
        #1;
        vecs++;
        if ({Stall_MEM, PCSrc, Branch_Target} !== {1'b1, 1'b1, 32'h80}) begin
            errs++; $display("FAIL branch_in_stall: got %b %b %h want 1 1 80", Stall_MEM, PCSrc, Branch_Target);
        end
        tick();
        Dmem_Ack = 1; Dmem_Rdata = 32'h1111_2222;
        #1;
        tick();
        set_nop();
    endtask

    task automatic test_reset_busy();
        logic [138:0] snap;
        MemRead_MEM = 1; RegWrite_MEM = 1; ALU_Result_MEM = 32'h300; Write_Register_MEM = 5'd5;
        #1;
        tick();
        vecs++;
        if (Dmem_Req !== 1'b1) begin errs++; $display("FAIL rstbusy_req: got %b want 1", Dmem_Req); end
        Reset_n = 0;
        tick();
        snap = {Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, RegWrite_WB, MemtoReg_WB,
                Read_Data_WB, ALU_Result_WB, Write_Register_WB, Align_Error, Timeout_Error};
        vecs++;
        if (snap !== '0) begin errs++; $display("FAIL rstbusy_outputs: got %h want 0", snap); end
        Reset_n = 1; set_nop(); Dmem_Ack = 1; Dmem_Rdata = 32'hBAD0BAD0;
        #1;
        vecs++;
        if (Stall_MEM !== 1'b0) begin errs++; $display("FAIL rstbusy_late_ack_stall: got %b want 0", Stall_MEM); end
        tick();
        vecs++;
        if ({Dmem_Req, Read_Data_WB} !== 33'h0) begin errs++; $display("FAIL rstbusy_late_ack: req %b rd %h want 0 0", Dmem_Req, Read_Data_WB); end
        set_nop();
    endtask

`ifdef MEM_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        MemRead_MEM = 1; RegWrite_MEM = 1; ALU_Result_MEM = 32'h400; Write_Register_MEM = 5'd6;
        #1;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            #1;
            if ({Dmem_Req, Stall_MEM, Timeout_Error} !== {1'b1, k < TMO, 1'b0}) bad++;
            tick();
            if (k < TMO && RegWrite_WB !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL timeout_wait: %0d bad cycles want 0", bad); end
        vecs++;
        if ({Dmem_Req, Timeout_Error, RegWrite_WB} !== 3'b010) begin
            errs++; $display("FAIL timeout_abort: req,tmo,rw got %b want 010", {Dmem_Req, Timeout_Error, RegWrite_WB});
        end
        set_nop();
        #1;
        tick();
        vecs++;
        if (Timeout_Error !== 1'b0) begin errs++; $display("FAIL timeout_pulse: got %b want 0", Timeout_Error); end
    endtask
`else
    task automatic test_timeout();
        int bad = 0;
        MemRead_MEM = 1; RegWrite_MEM = 1; ALU_Result_MEM = 32'h400; Write_Register_MEM = 5'd6;
        #1;
        tick();
        for (int k = 1; k <= 300; k++) begin
            #1;
            if ({Dmem_Req, Stall_MEM, Timeout_Error, RegWrite_WB} !== 4'b1100) bad++;
            tick();
        end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL no_timeout_wait: %0d bad cycles want 0", bad); end
        Dmem_Ack = 1; Dmem_Rdata = 32'hCAFE_F00D;
        #1;
        tick();
        vecs++;
        if ({Dmem_Req, RegWrite_WB, Read_Data_WB} !== {1'b0, 1'b1, 32'hCAFEF00D}) begin
            errs++; $display("FAIL no_timeout_done: req %b rw %b rd %h", Dmem_Req, RegWrite_WB, Read_Data_WB);
        end
        set_nop();
    endtask
`endif

    // Random back-to-back stream. The model only knows instruction-level
    // rules: the cycle count, when the request is visible, and what MEM/WB
    // holds once the instruction retires.
    task automatic test_back_to_back();
        logic [31:0] m_rd, m_alu, addr, rdata;
        logic [4:0]  m_wr;
        logic        m_rw, m_mtr, is_mem, last;
        int          kind, waits, nc;
        m_rd = 0; m_alu = 0; m_wr = 0; m_rw = 0; m_mtr = 0;
        Reset_n = 0; set_nop(); tick(); Reset_n = 1;
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            waits = int'($urandom_range(0, 3));
            addr = $urandom; rdata = $urandom;
            RegWrite_MEM = 1'($urandom); MemtoReg_MEM = 1'($urandom);
            Write_Register_MEM = 5'($urandom); Write_Data_MEM = $urandom;
            MemRead_MEM = 0; MemWrite_MEM = 0;
            case (kind)
                1: begin MemRead_MEM = 1; addr[1:0] = 2'b00; end
                2: begin MemWrite_MEM = 1; MemRead_MEM = 1'($urandom); addr[1:0] = 2'b00; end
                3: begin
                    MemRead_MEM = 1'($urandom); MemWrite_MEM = ~MemRead_MEM;
                    if (addr[1:0] == 2'b00) addr[1:0] = 2'b01;
                end
                default: ;
            endcase
            ALU_Result_MEM = addr;
            is_mem = (kind == 1) || (kind == 2);
            nc = is_mem ? waits + 2 : 1;
            for (int k = 0; k < nc; k++) begin
                last = (k == nc - 1);
                Branch_MEM = 1'($urandom); Zero_MEM = 1'($urandom); Branch_Dest_MEM = $urandom;
                Dmem_Ack = is_mem ? last : 1'($urandom);
                Dmem_Rdata = (last && kind == 1) ? rdata : $urandom;
                #1;
                vecs++;
                if ({Stall_MEM, PCSrc, Branch_Target} !== {is_mem && !last, Branch_MEM & Zero_MEM, Branch_Dest_MEM}) begin
                    errs++; $display("FAIL rnd_comb n%0d k%0d: stall %b pcsrc %b tgt %h", n, k, Stall_MEM, PCSrc, Branch_Target);
                end
                vecs++;
                if (is_mem && k > 0) begin
                    if ({Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata} !== {1'b1, kind == 2, addr, Write_Data_MEM}) begin
                        errs++; $display("FAIL rnd_req n%0d k%0d: req %b we %b addr %h wdata %h want 1 %b %h %h",
                                         n, k, Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, kind == 2, addr, Write_Data_MEM);
                    end
                end else if (Dmem_Req !== 1'b0) begin
                    errs++; $display("FAIL rnd_noreq n%0d k%0d: req got %b want 0", n, k, Dmem_Req);
                end
                tick();
                if (last) begin
                    m_rw = RegWrite_MEM && (kind != 3); m_mtr = MemtoReg_MEM;
                    m_alu = addr; m_wr = Write_Register_MEM;
                    if (kind == 1) m_rd = rdata;
                end else begin
                    m_rw = 0; m_mtr = 0;
                end
                vecs++;
                if ({RegWrite_WB, MemtoReg_WB, Write_Register_WB, ALU_Result_WB, Read_Data_WB, Align_Error, Timeout_Error}
                    !== {m_rw, m_mtr, m_wr, m_alu, m_rd, kind == 3, 1'b0}) begin
                    errs++; $display("FAIL rnd_wb n%0d k%0d: rw %b mtr %b wr %0d alu %h rd %h al %b to %b want %b %b %0d %h %h %b 0",
                                     n, k, RegWrite_WB, MemtoReg_WB, Write_Register_WB, ALU_Result_WB, Read_Data_WB,
                                     Align_Error, Timeout_Error, m_rw, m_mtr, m_wr, m_alu, m_rd, kind == 3);
                end
            end
        end
        set_nop();
    endtask

    initial begin
        set_nop();
        Reset_n = 0;
        test_reset();
        test_load_fast();
        test_store_wait();
        test_misaligned();
        test_branch();
        test_reset_busy();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
